// File: rtl/framebuffer_ctrl.sv
// ---------------------------------------------------------------------------
// framebuffer_ctrl
//
// Double-buffered 320x240x3-bit framebuffer. The renderer writes pixels into
// the back bank and the VGA scan-out reads from the front bank. Before each
// frame the back bank is cleared to SKY_COLOR. The renderer is told it may
// start with a one-cycle render_ack pulse. The banks swap at the first
// frame_start after the renderer reports render_done.
//
// Ports
//   Clk            system clock (only clock)
//   Reset          asynchronous, active-high reset
//   coords_in      write coordinates, x = coords_in[16:8], y = coords_in[7:0]
//   color_in       write colour
//   framebuffer_we write strobe, a write is taken every cycle it is high
//   render_done    one-cycle pulse: renderer finished the frame
//   render_ack     one-cycle pulse: back bank cleared, renderer may start
//   frame_start    one-cycle pulse at the start of vertical blank
//   DrawX, DrawY   VGA scan position (0..799, 0..524)
//   pixel_color    front-bank colour for the scan position of 2 cycles ago
//   front_sel      bank currently displayed
//   frame_count    number of completed swaps, wraps at 255
// ---------------------------------------------------------------------------
module framebuffer_ctrl #(
   parameter logic [2:0] SKY_COLOR = 3'd5
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [16:0] coords_in,
   input  logic [2:0]  color_in,
   input  logic        framebuffer_we,
   input  logic        render_done,
   output logic        render_ack,
   input  logic        frame_start,
   input  logic [9:0]  DrawX,
   input  logic [9:0]  DrawY,
   output logic [2:0]  pixel_color,
   output logic        front_sel,
   output logic [7:0]  frame_count
);

   localparam int unsigned NumPixels = 76800;
   localparam logic [16:0] LastAddr  = 17'd76799;

   typedef enum logic [1:0] {
      StClear,
      StAck,
      StRendering,
      StWaitSwap
   } state_t;

   state_t      state_q;
   logic [16:0] clearCnt_q;
   logic        frontSel_q;
   logic [7:0]  frameCount_q;
   logic        renderAck_q;

   // Two disjoint banks. Only the back bank is ever written and only the
   // front bank is ever read, so reads are never stalled by writes.
   logic [2:0]  bank0 [NumPixels];
   logic [2:0]  bank1 [NumPixels];

   logic [8:0]  wrX;
   logic [7:0]  wrY;
   logic        wrInRange;
   logic [16:0] wrLinAddr;

   logic        wrEn;
   logic [16:0] wrAddr;
   logic [2:0]  wrData;
   logic        wrBank;

   logic        rdValid_d;
   logic [16:0] rdAddr_d;
   logic [16:0] rdAddr_q;
   logic        rdValid_q;
   logic        rdBank_q;
   logic [2:0]  ramOut_q;
   logic        pixValid_q;

   logic        unusedLsbs;

   // The column and row LSBs only select the duplicated half of each
   // doubled pixel, so they never reach the address.
   assign unusedLsbs = ^{DrawX[0], DrawY[0]};

   // Renderer coordinates and their linear address, y*320 + x built from
   // shifts so no multiplier is needed.
   assign wrX       = coords_in[16:8];
   assign wrY       = coords_in[7:0];
   assign wrInRange = (wrX <= 9'd319) && (wrY <= 8'd239);
   assign wrLinAddr = {1'b0, wrY, 8'b0} + {3'b0, wrY, 6'b0} + {8'b0, wrX};

   // The back bank is always the one not on screen.
   assign wrBank = ~frontSel_q;

   // Single write port shared between the clear sweep and the renderer.
   // Only one of the two can be active, because writes from the renderer
   // are honoured in RENDERING alone.
   always_comb begin
      wrEn   = 1'b0;
      wrAddr = clearCnt_q;
      wrData = SKY_COLOR;
      case (state_q)
         StClear: begin
            wrEn = 1'b1;
         end
         StRendering: begin
            if (framebuffer_we && wrInRange) begin
               wrEn   = 1'b1;
               wrAddr = wrLinAddr;
               wrData = color_in;
            end
         end
         default: begin
            wrEn = 1'b0;
         end
      endcase
   end

   // Bank storage. The contents survive Reset; a clear rebuilds the back
   // bank before it is ever displayed.
   always_ff @(posedge Clk) begin
      if (wrEn && !wrBank) begin
         bank0[wrAddr] <= wrData;
      end
      if (wrEn && wrBank) begin
         bank1[wrAddr] <= wrData;
      end
   end

   // Frame sequencing: clear the back bank, hand it to the renderer, wait
   // for the renderer to finish, then swap at vertical blank. render_ack is
   // registered alongside the transition into ACK, so it is high for the
   // single cycle spent in that state.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q      <= StClear;
         clearCnt_q   <= 17'd0;
         frontSel_q   <= 1'b0;
         frameCount_q <= 8'd0;
         renderAck_q  <= 1'b0;
      end else begin
         renderAck_q <= 1'b0;
         case (state_q)
            StClear: begin
               if (clearCnt_q == LastAddr) begin
                  clearCnt_q  <= 17'd0;
                  renderAck_q <= 1'b1;
                  state_q     <= StAck;
               end else begin
                  clearCnt_q <= clearCnt_q + 17'd1;
               end
            end
            StAck: begin
               state_q <= StRendering;
            end
            StRendering: begin
               if (render_done) begin
                  state_q <= StWaitSwap;
               end
            end
            StWaitSwap: begin
               if (frame_start) begin
                  frontSel_q   <= ~frontSel_q;
                  frameCount_q <= frameCount_q + 8'd1;
                  state_q      <= StClear;
               end
            end
            default: begin
               state_q <= StClear;
            end
         endcase
      end
   end

   // Scan-out address: 2x pixel doubling, so the bank coordinate is the
   // scan position halved. Off-screen positions park the address at 0 and
   // are flagged invalid so they come out as blanking.
   always_comb begin
      rdValid_d = (DrawX < 10'd640) && (DrawY < 10'd480);
      rdAddr_d  = 17'd0;
      if (rdValid_d) begin
         rdAddr_d = {1'b0, DrawY[8:1], 8'b0} + {3'b0, DrawY[8:1], 6'b0}
                  + {8'b0, DrawX[9:1]};
      end
   end

   // Read pipeline control. Stage 1 captures the address, the in-range
   // flag and the bank that was on screen when the read was issued, so a
   // read issued in the swap cycle still targets the old front bank.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         rdAddr_q   <= 17'd0;
         rdValid_q  <= 1'b0;
         rdBank_q   <= 1'b0;
         pixValid_q <= 1'b0;
      end else begin
         rdAddr_q   <= rdAddr_d;
         rdValid_q  <= rdValid_d;
         rdBank_q   <= frontSel_q;
         pixValid_q <= rdValid_q;
      end
   end

   // Stage 2 RAM output register. It is kept reset-free so it maps onto a
   // block RAM output register; blanking and reset are applied by the
   // validity flag that travels beside it.
   always_ff @(posedge Clk) begin
      ramOut_q <= rdBank_q ? bank1[rdAddr_q] : bank0[rdAddr_q];
   end

   assign pixel_color = pixValid_q ? ramOut_q : 3'd0;
   assign render_ack  = renderAck_q;
   assign front_sel   = frontSel_q;
   assign frame_count = frameCount_q;

endmodule

// File: tb/tb_framebuffer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_framebuffer_ctrl
//
// Drives randomized renderer and scan-out traffic into framebuffer_ctrl and
// compares every output on every cycle against a behavioural model of the
// frame sequence and the two banks. A few literal expectations pin the
// model: ack timing, swap behaviour, doubled and blanked reads, dropped
// writes and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_framebuffer_ctrl;

   localparam logic [2:0] Sky    = 3'd5;
   localparam int         NumPix = 76800;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [16:0] coords;
   logic [2:0]  colorIn;
   logic        we;
   logic        done;
   logic        fs;
   logic [9:0]  drawX;
   logic [9:0]  drawY;
   logic        ack;
   logic [2:0]  pix;
   logic        front;
   logic [7:0]  count;

   int errors = 0;
   int checks = 0;

   // Behavioural model state
   logic [2:0] mBank [2][NumPix];
   bit         mKnown [2];
   int         mClearLeft;
   bit         mAck;
   bit         mRender;
   bit         mWait;
   bit         mFront;
   int         mCount;
   int         exp1;
   int         exp2;
   bit         exp1Known;
   bit         exp2Known;
   bit         checkEn = 1'b0;

   always #5 clk = ~clk;

   framebuffer_ctrl #(.SKY_COLOR(Sky)) dut (
      .Clk            (clk),
      .Reset          (rst),
      .coords_in      (coords),
      .color_in       (colorIn),
      .framebuffer_we (we),
      .render_done    (done),
      .render_ack     (ack),
      .frame_start    (fs),
      .DrawX          (drawX),
      .DrawY          (drawY),
      .pixel_color    (pix),
      .front_sel      (front),
      .frame_count    (count)
   );

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input bit weV, input int x, input int y, input int c,
                                input bit doneV, input bit fsV, input int dx, input int dy);
      we      = weV;
      coords  = {x[8:0], y[7:0]};
      colorIn = c[2:0];
      done    = doneV;
      fs      = fsV;
      drawX   = dx[9:0];
      drawY   = dy[9:0];
   endtask

   // One cycle of the frame sequence at the level of the rules: a clear is
   // just a countdown that leaves the back bank all sky when it finishes,
   // reads look up the bank on screen when they are issued, and results
   // emerge two clocks later.
   task automatic modelStep();
      int  addr;
      int  x;
      int  y;
      bit  wasAck;
      exp2      = exp1;
      exp2Known = exp1Known;
      if (drawX < 10'd640 && drawY < 10'd480) begin
         addr      = (int'(drawY) / 2) * 320 + int'(drawX) / 2;
         exp1      = int'(mBank[mFront][addr]);
         exp1Known = mKnown[mFront];
      end else begin
         exp1      = 0;
         exp1Known = 1'b1;
      end
      wasAck = mAck;
      mAck   = 1'b0;
      if (mClearLeft > 0) begin
         mClearLeft--;
         if (mClearLeft == 0) begin
            for (int i = 0; i < NumPix; i++) mBank[!mFront][i] = Sky;
            mKnown[!mFront] = 1'b1;
            mAck            = 1'b1;
         end
      end else if (wasAck) begin
         mRender = 1'b1;
      end else if (mRender) begin
         if (we) begin
            x = int'(coords[16:8]);
            y = int'(coords[7:0]);
            if (x < 320 && y < 240) mBank[!mFront][y * 320 + x] = colorIn;
         end
         if (done) begin
            mRender = 1'b0;
            mWait   = 1'b1;
         end
      end else if (mWait && fs) begin
         mWait           = 1'b0;
         mFront          = !mFront;
         mCount          = (mCount + 1) % 256;
         mKnown[!mFront] = 1'b0;
         mClearLeft      = NumPix;
      end
   endtask

   // Model update, following the DUT's reset and clock. Bank contents are
   // kept across reset; only the bank about to be cleared becomes unknown.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mClearLeft = NumPix;
         mAck       = 1'b0;
         mRender    = 1'b0;
         mWait      = 1'b0;
         mFront     = 1'b0;
         mCount     = 0;
         mKnown[1]  = 1'b0;
         exp1       = 0;
         exp2       = 0;
         exp1Known  = 1'b1;
         exp2Known  = 1'b1;
      end else begin
         modelStep();
      end
   end

   // Every-cycle comparison of all outputs against the model, half a clock
   // away from the active edge.
   always @(negedge clk) begin
      if (checkEn && !rst) begin
         checkOutput("render_ack", int'(ack), int'(mAck));
         checkOutput("front_sel", int'(front), int'(mFront));
         checkOutput("frame_count", int'(count), mCount);
         if (exp2Known) checkOutput("pixel_color", int'(pix), exp2);
      end
   end

   // Anything goes while the back bank is being cleared.
   task automatic clearRandom();
      applyStimulus(($urandom % 2) == 1, int'($urandom % 512), int'($urandom % 256),
                    int'($urandom % 8), ($urandom % 400) == 0, ($urandom % 400) == 0,
                    int'($urandom % 800), int'($urandom % 525));
   endtask

   // Rendering traffic near the bottom-right corner, partly off-screen.
   task automatic renderRandom();
      applyStimulus(($urandom % 4) != 0, 100 + int'($urandom % 231), 100 + int'($urandom % 151),
                    int'($urandom % 8), 1'b0, ($urandom % 50) == 0,
                    int'($urandom % 800), int'($urandom % 525));
   endtask

   // Scan-out mostly over the rendered region, sometimes anywhere.
   task automatic scanRandom();
      int dx;
      int dy;
      if (($urandom % 4) != 0) begin
         dx = 2 * (100 + int'($urandom % 220)) + int'($urandom % 2);
         dy = 2 * (100 + int'($urandom % 140)) + int'($urandom % 2);
      end else begin
         dx = int'($urandom % 800);
         dy = int'($urandom % 525);
      end
      applyStimulus(($urandom % 2) == 1, int'($urandom % 512), int'($urandom % 256),
                    int'($urandom % 8), ($urandom % 100) == 0, ($urandom % 100) == 0, dx, dy);
   endtask

   // Issue one read and check the result two clocks later.
   task automatic readPixel(input int dx, input int dy, input int expected, input string name);
      applyStimulus(1'b0, 0, 0, 0, 1'b0, 1'b0, dx, dy);
      @(negedge clk);
      @(negedge clk);
      checkOutput(name, int'(pix), expected);
   endtask

   // Main sequence
   initial begin
      int ackFirst;
      int ackCount;
      int ackLate;
      ackFirst = -1;
      ackCount = 0;
      ackLate  = 0;

      applyStimulus(1'b0, 0, 0, 0, 1'b0, 1'b0, 0, 0);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst     = 1'b0;
      checkEn = 1'b1;
      $display("[TB] reset released, clearing back bank");

      // Clear, ack and the first render cycle. Cycle 76800 is the last
      // clear cycle and 76801 is the ack cycle; both carry writes that must
      // be dropped, and render_done during ack is ignored.
      for (int i = 1; i <= 76802; i++) begin
         if (i <= 76799) clearRandom();
         else if (i == 76800) applyStimulus(1'b1, 11, 20, 1, 1'b0, 1'b0, 0, 0);
         else if (i == 76801) applyStimulus(1'b1, 0, 6, 1, 1'b1, 1'b0, 0, 0);
         else renderRandom();
         @(negedge clk);
         if (ack) begin
            ackCount++;
            if (ackFirst < 0) ackFirst = i;
         end
      end
      checkOutput("ack cycle after release", ackFirst, 76800);
      checkOutput("ack pulse count", ackCount, 1);

      repeat (1500) begin
         renderRandom();
         @(negedge clk);
      end

      applyStimulus(1'b1, 10, 20, 2, 1'b0, 1'b0, 0, 0);
      @(negedge clk);
      applyStimulus(1'b1, 320, 5, 7, 1'b0, 1'b0, 0, 0);
      @(negedge clk);
      applyStimulus(1'b1, 3, 240, 7, 1'b0, 1'b0, 0, 0);
      @(negedge clk);
      applyStimulus(1'b1, 319, 239, 6, 1'b1, 1'b1, 0, 0);
      @(negedge clk);
      checkOutput("front_sel after done+frame_start", int'(front), 0);
      checkOutput("frame_count after done+frame_start", int'(count), 0);

      // Waiting for vertical blank: writes and extra done pulses are ignored.
      for (int k = 0; k < 20; k++) begin
         applyStimulus(1'b1, int'($urandom % 512), int'($urandom % 256), int'($urandom % 8),
                       ($urandom % 3) == 0, 1'b0, 0, 0);
         @(negedge clk);
      end
      applyStimulus(1'b0, 0, 0, 0, 1'b0, 1'b1, 0, 0);
      @(negedge clk);
      checkOutput("front_sel after swap", int'(front), 1);
      checkOutput("frame_count after swap", int'(count), 1);
      $display("[TB] swapped, checking scan-out");

      readPixel(20, 40, 2, "pixel (20,40)");
      readPixel(21, 41, 2, "pixel (21,41)");
      readPixel(22, 40, int'(Sky), "pixel (22,40)");
      readPixel(639, 479, 6, "pixel (639,479)");
      readPixel(640, 0, 0, "blank DrawX=640");
      readPixel(100, 480, 0, "blank DrawY=480");
      readPixel(0, 12, int'(Sky), "pixel (0,12)");
      readPixel(638, 10, int'(Sky), "pixel (638,10)");
      readPixel(6, 478, int'(Sky), "pixel (6,478)");

      repeat (2500) begin
         scanRandom();
         @(negedge clk);
      end

      // Asynchronous reset in the middle of a frame.
      readPixel(20, 40, 2, "pixel before reset");
      #1;
      rst = 1'b1;
      #1;
      checkOutput("render_ack in reset", int'(ack), 0);
      checkOutput("front_sel in reset", int'(front), 0);
      checkOutput("frame_count in reset", int'(count), 0);
      checkOutput("pixel_color in reset", int'(pix), 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      $display("[TB] reset released mid-frame");

      for (int i = 0; i < 1000; i++) begin
         clearRandom();
         @(negedge clk);
         if (ack) ackLate++;
      end
      checkOutput("no early ack after reset", ackLate, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
